// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, write-enable encodings and source identifiers for the write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned RADDR_WIDTH = 5;
  localparam int unsigned RDATA_WIDTH = 32;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;
  localparam logic [RDATA_WIDTH-1:0] ZERO     = '0;

  typedef enum logic {
    WB_SRC_A = 1'b0,
    WB_SRC_B = 1'b1
  } wb_src_e;

  // Width of a counter able to hold 0..2*depth pending entries.
  function automatic int unsigned pend_width(input int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Per-source write-back FIFO with wrap-bit pointers and per-entry address visibility
// so the top level can detect read-after-write hazards on buffered results.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = RADDR_WIDTH,
  parameter int unsigned DW    = RDATA_WIDTH,
  localparam int unsigned IW   = $clog2(DEPTH),
  localparam int unsigned PW   = IW + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push,
  input  logic                      pop,
  input  logic [AW-1:0]             din_waddr,
  input  logic [DW-1:0]             din_wdata,
  output logic [AW-1:0]             dout_waddr,
  output logic [DW-1:0]             dout_wdata,
  output logic                      empty,
  output logic                      full,
  output logic [PW-1:0]             count,
  output logic [DEPTH-1:0]          ent_valid,
  output logic [DEPTH-1:0][AW-1:0]  ent_waddr
);

  logic [AW-1:0] waddr_mem [DEPTH];
  logic [DW-1:0] wdata_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign wr_idx  = wr_ptr[IW-1:0];
  assign rd_idx  = rd_ptr[IW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_idx == rd_idx);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      waddr_mem[wr_idx] <= din_waddr;
      wdata_mem[wr_idx] <= din_wdata;
    end
  end

  assign dout_waddr = waddr_mem[rd_idx];
  assign dout_wdata = wdata_mem[rd_idx];

  // A slot is live when its distance from the read index is below the fill level.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [IW-1:0] offs;
    assign offs         = IW'(g) - rd_idx;
    assign ent_valid[g] = ({1'b0, offs} < count);
    assign ent_waddr[g] = waddr_mem[g];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of the ALU (A) and LSU (B) write-back streams onto the single
// regfile write port, with a combinational ID stall for reads of buffered results.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = RADDR_WIDTH,
  parameter int unsigned DW    = RDATA_WIDTH,
  localparam int unsigned PW   = $clog2(DEPTH) + 1,
  localparam int unsigned CW   = pend_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          a_valid_i,
  output logic          a_ready_o,
  input  logic [AW-1:0] a_waddr_i,
  input  logic [DW-1:0] a_wdata_i,
  input  logic          b_valid_i,
  output logic          b_ready_o,
  input  logic [AW-1:0] b_waddr_i,
  input  logic [DW-1:0] b_wdata_i,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic [DW-1:0] wdata_o,
  input  logic [AW-1:0] hz_raddr1_i,
  input  logic [AW-1:0] hz_raddr2_i,
  output logic          hz_stall_o,
  output logic [CW-1:0] pend_cnt_o
);

  logic                     a_push, b_push;
  logic                     a_pop,  b_pop;
  logic                     a_empty, b_empty;
  logic                     a_full,  b_full;
  logic [PW-1:0]            a_count, b_count;
  logic [AW-1:0]            a_head_waddr, b_head_waddr;
  logic [DW-1:0]            a_head_wdata, b_head_wdata;
  logic [DEPTH-1:0]         a_ent_valid, b_ent_valid;
  logic [DEPTH-1:0][AW-1:0] a_ent_waddr, b_ent_waddr;

  wb_src_e       rr_last;
  wb_src_e       sel;
  logic          any_pop;
  logic          rr_upd;
  logic [AW-1:0] sel_waddr;
  logic [DW-1:0] sel_wdata;
  logic [CW-1:0] pend_next;

  function automatic logic rd_hit(input logic [AW-1:0] w,
                                  input logic [AW-1:0] r1,
                                  input logic [AW-1:0] r2);
    return ((r1 != AW'(ZERO_REG)) && (w == r1)) ||
           ((r2 != AW'(ZERO_REG)) && (w == r2));
  endfunction

  assign a_ready_o = !rst_i && !a_full;
  assign b_ready_o = !rst_i && !b_full;

  // Writes to the zero register complete the handshake but are never buffered.
  assign a_push = a_valid_i && a_ready_o && (a_waddr_i != AW'(ZERO_REG));
  assign b_push = b_valid_i && b_ready_o && (b_waddr_i != AW'(ZERO_REG));

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_a (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (a_push),
    .pop        (a_pop),
    .din_waddr  (a_waddr_i),
    .din_wdata  (a_wdata_i),
    .dout_waddr (a_head_waddr),
    .dout_wdata (a_head_wdata),
    .empty      (a_empty),
    .full       (a_full),
    .count      (a_count),
    .ent_valid  (a_ent_valid),
    .ent_waddr  (a_ent_waddr)
  );

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_b (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (b_push),
    .pop        (b_pop),
    .din_waddr  (b_waddr_i),
    .din_wdata  (b_wdata_i),
    .dout_waddr (b_head_waddr),
    .dout_wdata (b_head_wdata),
    .empty      (b_empty),
    .full       (b_full),
    .count      (b_count),
    .ent_valid  (b_ent_valid),
    .ent_waddr  (b_ent_waddr)
  );

  // Grant: on contention the source that did not win last time goes first.
  always_comb begin
    sel     = rr_last;
    rr_upd  = 1'b0;
    any_pop = !a_empty || !b_empty;
    if (!a_empty && !b_empty) begin
      sel    = (rr_last == WB_SRC_A) ? WB_SRC_B : WB_SRC_A;
      rr_upd = 1'b1;
    end else if (!a_empty) begin
      sel = WB_SRC_A;
    end else if (!b_empty) begin
      sel = WB_SRC_B;
    end
    a_pop     = !a_empty && (sel == WB_SRC_A);
    b_pop     = !b_empty && (sel == WB_SRC_B);
    sel_waddr = (sel == WB_SRC_A) ? a_head_waddr : b_head_waddr;
    sel_wdata = (sel == WB_SRC_A) ? a_head_wdata : b_head_wdata;
  end

  assign pend_next = CW'(a_count) + CW'(b_count) + CW'(a_push) + CW'(b_push)
                   - CW'(a_pop) - CW'(b_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_last    <= WB_SRC_B;
      we_o       <= WRITE_DISABLE;
      waddr_o    <= AW'(ZERO_REG);
      wdata_o    <= DW'(ZERO);
      pend_cnt_o <= '0;
    end else begin
      if (rr_upd) rr_last <= sel;
      we_o       <= any_pop ? WRITE_ENABLE : WRITE_DISABLE;
      pend_cnt_o <= pend_next;
      if (any_pop) begin
        waddr_o <= sel_waddr;
        wdata_o <= sel_wdata;
      end
    end
  end

  // The output stage is not included: the regfile forwards same-cycle writes.
  always_comb begin
    hz_stall_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (a_ent_valid[i] && rd_hit(a_ent_waddr[i], hz_raddr1_i, hz_raddr2_i)) hz_stall_o = 1'b1;
      if (b_ent_valid[i] && rd_hit(b_ent_waddr[i], hz_raddr1_i, hz_raddr2_i)) hz_stall_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, ordering sequences and a random
// phase, all checked against a queue-based model of the two write-back buffers.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = $clog2(2 * DEPTH + 1);

  logic          clk_i;
  logic          rst_i;
  logic          a_valid_i, b_valid_i;
  logic          a_ready_o, b_ready_o;
  logic [AW-1:0] a_waddr_i, b_waddr_i;
  logic [DW-1:0] a_wdata_i, b_wdata_i;
  logic          we_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;
  logic [AW-1:0] hz_raddr1_i, hz_raddr2_i;
  logic          hz_stall_o;
  logic [CW-1:0] pend_cnt_o;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .a_valid_i   (a_valid_i),
    .a_ready_o   (a_ready_o),
    .a_waddr_i   (a_waddr_i),
    .a_wdata_i   (a_wdata_i),
    .b_valid_i   (b_valid_i),
    .b_ready_o   (b_ready_o),
    .b_waddr_i   (b_waddr_i),
    .b_wdata_i   (b_wdata_i),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .hz_raddr1_i (hz_raddr1_i),
    .hz_raddr2_i (hz_raddr2_i),
    .hz_stall_o  (hz_stall_o),
    .pend_cnt_o  (pend_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct {
    logic          rst;
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bv;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic          e_we;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    logic          e_ar;
    logic          e_br;
    logic [CW-1:0] e_pend;
    logic          e_hz;
  } vec_t;

  // Model state: buffered entries per source, arbitration memory, expected write port.
  ent_t          qa[$];
  ent_t          qb[$];
  logic          m_rr_b;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic          m_chk_data;
  logic          acc_a, acc_b;

  int            n_cmp;
  int            n_fail;
  int unsigned   wlog[$];
  vec_t          tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic hit(input logic [AW-1:0] w);
    return ((hz_raddr1_i != 0) && (w == hz_raddr1_i)) || ((hz_raddr2_i != 0) && (w == hz_raddr2_i));
  endfunction

  function automatic logic model_hz();
    logic h = 1'b0;
    foreach (qa[i]) if (hit(qa[i].a)) h = 1'b1;
    foreach (qb[i]) if (hit(qb[i].a)) h = 1'b1;
    return h;
  endfunction

  // Advances the model across one rising edge using the inputs currently applied.
  task automatic model_step();
    ent_t e;
    int   src;
    if (rst_i) begin
      qa.delete();
      qb.delete();
      m_rr_b     = 1'b1;
      m_we       = 1'b0;
      m_waddr    = '0;
      m_wdata    = '0;
      m_chk_data = 1'b1;
      acc_a      = 1'b0;
      acc_b      = 1'b0;
    end else begin
      acc_a = a_valid_i && (qa.size() < DEPTH);
      acc_b = b_valid_i && (qb.size() < DEPTH);
      src = -1;
      if (qa.size() > 0 && qb.size() > 0) begin
        src    = m_rr_b ? 0 : 1;
        m_rr_b = (src == 1);
      end else if (qa.size() > 0) src = 0;
      else if (qb.size() > 0) src = 1;
      if (src == 0) e = qa.pop_front();
      if (src == 1) e = qb.pop_front();
      m_we       = (src >= 0);
      m_chk_data = (src >= 0);
      if (src >= 0) begin
        m_waddr = e.a;
        m_wdata = e.d;
      end
      if (acc_a && a_waddr_i != 0) qa.push_back('{a_waddr_i, a_wdata_i});
      if (acc_b && b_waddr_i != 0) qb.push_back('{b_waddr_i, b_wdata_i});
    end
  endtask

  // Called at a falling edge with inputs applied; checks, logs, then crosses the next edge.
  task automatic cycle();
    #1;
    chk("we", 64'(we_o), 64'(m_we));
    if (m_chk_data) begin
      chk("waddr", 64'(waddr_o), 64'(m_waddr));
      chk("wdata", 64'(wdata_o), 64'(m_wdata));
    end
    chk("a_ready", 64'(a_ready_o), 64'(!rst_i && qa.size() < DEPTH));
    chk("b_ready", 64'(b_ready_o), 64'(!rst_i && qb.size() < DEPTH));
    chk("pend", 64'(pend_cnt_o), 64'(qa.size() + qb.size()));
    chk("hz", 64'(hz_stall_o), 64'(model_hz()));
    if (we_o === 1'b1) wlog.push_back(32'(waddr_o));
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    rst_i = 1'b0;
    a_valid_i = 1'b0; a_waddr_i = '0; a_wdata_i = '0;
    b_valid_i = 1'b0; b_waddr_i = '0; b_wdata_i = '0;
    hz_raddr1_i = '0; hz_raddr2_i = '0;
  endtask

  initial begin
    int ai, bi, cyc, bstall, pend_now;
    int unsigned blog[$];
    int unsigned exp3[8];

    //       rst av aa  ad            bv ba  bd      r1  r2  we wa  wd            ar br pend hz
    tbl[0]  = '{1, 0, 0, 0,            0, 0, 0,      0,  0,  0, 0, 0,            0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0,            0, 0, 0,      0,  0,  0, 0, 0,            1, 1, 0, 0};
    tbl[2]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 0,      0,  0,  0, 0, 0,            1, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0,            0, 0, 0,      5,  0,  0, 0, 0,            1, 1, 1, 1};
    tbl[4]  = '{0, 0, 0, 0,            0, 0, 0,      5,  0,  1, 5, 32'hDEADBEEF, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0,            0, 0, 0,      0,  5,  0, 0, 0,            1, 1, 0, 0};
    tbl[6]  = '{0, 1, 0, 32'h1234,     0, 0, 0,      0,  0,  0, 0, 0,            1, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0,            0, 0, 0,      0,  0,  0, 0, 0,            1, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 0,            1, 7, 32'h77, 0,  7,  0, 0, 0,            1, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 0,            0, 0, 0,      0,  7,  0, 0, 0,            1, 1, 1, 1};
    tbl[10] = '{0, 0, 0, 0,            0, 0, 0,      0,  7,  1, 7, 32'h77,       1, 1, 0, 0};
    exp3 = '{1, 11, 2, 12, 3, 13, 4, 14};
    n_cmp = 0;
    n_fail = 0;

    idle();
    rst_i = 1'b1;
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    cycle();

    // Directed vectors: reset hold/release, single A/B write latency, r0 write, hazards.
    foreach (tbl[i]) begin
      rst_i = tbl[i].rst;
      a_valid_i = tbl[i].av; a_waddr_i = tbl[i].aa; a_wdata_i = tbl[i].ad;
      b_valid_i = tbl[i].bv; b_waddr_i = tbl[i].ba; b_wdata_i = tbl[i].bd;
      hz_raddr1_i = tbl[i].r1; hz_raddr2_i = tbl[i].r2;
      #1;
      chk("tbl_we", 64'(we_o), 64'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk("tbl_waddr", 64'(waddr_o), 64'(tbl[i].e_wa));
        chk("tbl_wdata", 64'(wdata_o), 64'(tbl[i].e_wd));
      end
      chk("tbl_a_ready", 64'(a_ready_o), 64'(tbl[i].e_ar));
      chk("tbl_b_ready", 64'(b_ready_o), 64'(tbl[i].e_br));
      chk("tbl_pend", 64'(pend_cnt_o), 64'(tbl[i].e_pend));
      chk("tbl_hz", 64'(hz_stall_o), 64'(tbl[i].e_hz));
      cycle();
    end

    // Both sources push every cycle; writes must interleave starting with A.
    idle();
    wlog.delete();
    ai = 0; bi = 0; cyc = 0;
    while (wlog.size() < 8 && cyc < 40) begin
      a_valid_i = (ai < 4); a_waddr_i = AW'(ai + 1);  a_wdata_i = 32'hA000 + 32'(ai);
      b_valid_i = (bi < 4); b_waddr_i = AW'(bi + 11); b_wdata_i = 32'hB000 + 32'(bi);
      cycle();
      if (acc_a) ai++;
      if (acc_b) bi++;
      cyc++;
    end
    chk("order_count", 64'(wlog.size()), 64'd8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) chk("order_rd", 64'(wlog[i]), 64'(exp3[i]));

    // B held valid while A contends: B fills, stalls, and its pointers wrap over 10 pushes.
    idle();
    wlog.delete();
    bi = 0; cyc = 0; bstall = 0;
    while ((bi < 10 || qa.size() + qb.size() > 0) && cyc < 80) begin
      a_valid_i = (bi < 10); a_waddr_i = 5'd2; a_wdata_i = 32'(cyc);
      b_valid_i = (bi < 10); b_waddr_i = AW'(16 + bi); b_wdata_i = 32'hC000 + 32'(bi);
      if (b_valid_i && qb.size() == DEPTH) bstall++;
      cycle();
      if (acc_b) bi++;
      cyc++;
    end
    idle();
    cycle();
    cycle();
    blog.delete();
    foreach (wlog[i]) if (wlog[i] >= 16) blog.push_back(wlog[i]);
    chk("b_stall_seen", 64'(bstall > 0), 64'd1);
    chk("b_count", 64'(blog.size()), 64'd10);
    for (int i = 0; i < 10 && i < blog.size(); i++) chk("b_order", 64'(blog[i]), 64'(16 + i));

    // Mid-operation reset with entries pending, then a tie must go to A first.
    idle();
    cyc = 0;
    pend_now = 0;
    while (pend_now < 3 && cyc < 10) begin
      a_valid_i = 1'b1; a_waddr_i = 5'd20; a_wdata_i = 32'(cyc);
      b_valid_i = 1'b1; b_waddr_i = 5'd21; b_wdata_i = 32'(cyc);
      cycle();
      pend_now = qa.size() + qb.size();
      cyc++;
    end
    chk("pre_reset_pend", 64'(pend_now), 64'd3);
    idle();
    rst_i = 1'b1;
    cycle();
    idle();
    wlog.delete();
    for (int i = 0; i < 4; i++) cycle();
    chk("post_reset_writes", 64'(wlog.size()), 64'd0);
    a_valid_i = 1'b1; a_waddr_i = 5'd3; a_wdata_i = 32'h33;
    b_valid_i = 1'b1; b_waddr_i = 5'd9; b_wdata_i = 32'h99;
    cycle();
    idle();
    for (int i = 0; i < 4; i++) cycle();
    chk("tie_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("tie_first", 64'(wlog[0]), 64'd3);
      chk("tie_second", 64'(wlog[1]), 64'd9);
    end

    // Random traffic with occasional resets, every cycle checked against the model.
    for (int i = 0; i < 600; i++) begin
      rst_i       = ($urandom_range(0, 49) == 0);
      a_valid_i   = ($urandom_range(0, 3) != 0);
      a_waddr_i   = AW'($urandom_range(0, 9));
      a_wdata_i   = $urandom();
      b_valid_i   = ($urandom_range(0, 3) != 0);
      b_waddr_i   = AW'($urandom_range(0, 9));
      b_wdata_i   = $urandom();
      hz_raddr1_i = AW'($urandom_range(0, 9));
      hz_raddr2_i = AW'($urandom_range(0, 9));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
